// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the data-memory sequencing controller:
// RV32I load/store funct3 codes, controller states and port identifiers.
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // Access width in bytes; funct3[2] only selects zero extension.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte/half lane handling: load extract with sign/zero extension, and the
// store-side merge of a byte or half into a previously read word.
module mem_lane_fmt
  import rv_mem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic        [7:0]  lane_b;
  logic        [15:0] lane_h;
  logic signed [7:0]  lane_b_s;
  logic signed [15:0] lane_h_s;

  always_comb begin
    lane_b   = word[{off, 3'b000} +: 8];
    lane_h   = word[{off[1], 4'b0000} +: 16];
    lane_b_s = lane_b;
    lane_h_s = lane_h;
    case (size)
      F3_B:    load_data = 32'(lane_b_s);
      F3_H:    load_data = 32'(lane_h_s);
      F3_BU:   load_data = {24'd0, lane_b};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size[1:0])
      2'b00:   merged[{off, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (core / debug) arbiter and sequencer in front of a word-write-only
// data memory; byte and half stores are done as read-modify-write.
module dmem_ctrl
  import rv_mem_pkg::*;
#(
  parameter int MEM_BYTES  = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [2:0]  c_size,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic        txn_port;
  logic        txn_we;
  logic [2:0]  txn_size;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;
  logic [31:0] merge_q;

  logic        dbg_wins;
  logic        f3_legal;
  logic        misalign;
  logic        out_of_range;
  logic        acc_err;
  logic        sub_store;
  logic        fin;
  logic        fin_err;
  logic [32:0] last_byte;
  logic [31:0] fin_data;
  logic [31:0] fmt_word;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Arbitration: core by default, debug when the core is quiet or starved out.
  always_comb begin
    dbg_wins = d_req && (!c_req || (starve_cnt == CNT_MAX));
    c_gnt    = (state == IDLE) && c_req && !dbg_wins;
    d_gnt    = (state == IDLE) && dbg_wins;
  end

  // Legality of the latched transaction; debug accesses are latched as words.
  always_comb begin
    f3_legal     = txn_we ? (txn_size inside {F3_B, F3_H, F3_W})
                          : (txn_size inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign     = ((txn_size[1:0] == 2'b01) && txn_addr[0]) ||
                   ((txn_size[1:0] == 2'b10) && (txn_addr[1:0] != 2'b00));
    last_byte    = {1'b0, txn_addr} + {30'd0, size_bytes(txn_size)} - 33'd1;
    out_of_range = last_byte >= 33'(MEM_BYTES);
    acc_err      = !f3_legal || misalign || out_of_range;
    sub_store    = txn_we && (txn_size != F3_W) && !acc_err;
  end

  always_comb begin
    fin      = ((state == ACCESS) && !sub_store) || (state == MERGE);
    fin_err  = (state == ACCESS) && acc_err;
    fin_data = ((state == ACCESS) && !txn_we && !acc_err) ? load_data : '0;
    fmt_word = (state == MERGE) ? merge_q : mem_rdata;
  end

  mem_lane_fmt u_fmt (
    .size      (txn_size),
    .off       (txn_addr[1:0]),
    .word      (fmt_word),
    .wdata     (txn_wdata[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  // Memory drive decodes straight from state so a reset kills a write at once.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      ACCESS: begin
        mem_addr = {txn_addr[31:2], 2'b00};
        if (txn_we && !acc_err && (txn_size == F3_W)) begin
          mem_we    = 1'b1;
          mem_wdata = txn_wdata;
        end
      end
      MERGE: begin
        mem_addr  = {txn_addr[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = merged;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      c_rvalid   <= 1'b0;
      c_err      <= 1'b0;
      c_rdata    <= '0;
      d_rvalid   <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      c_rvalid <= fin && (txn_port == PORT_CORE);
      c_err    <= fin_err && (txn_port == PORT_CORE);
      c_rdata  <= (txn_port == PORT_CORE) ? fin_data : '0;
      d_rvalid <= fin && (txn_port == PORT_DBG);
      d_err    <= fin_err && (txn_port == PORT_DBG);
      d_rdata  <= (txn_port == PORT_DBG) ? fin_data : '0;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            starve_cnt <= '0;
          end else if (d_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (c_gnt || d_gnt) begin
            state <= ACCESS;
          end
        end
        ACCESS:  state <= sub_store ? MERGE : IDLE;
        MERGE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Transaction and merge registers carry data only; state gates their use.
  always_ff @(posedge clk) begin
    if (c_gnt) begin
      txn_port  <= PORT_CORE;
      txn_we    <= c_we;
      txn_size  <= c_size;
      txn_addr  <= c_addr;
      txn_wdata <= c_wdata;
    end else if (d_gnt) begin
      txn_port  <= PORT_DBG;
      txn_we    <= d_we;
      txn_size  <= F3_W;
      txn_addr  <= d_addr;
      txn_wdata <= d_wdata;
    end
    if (state == ACCESS) begin
      merge_q <= mem_rdata;
    end
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Sequencing controller and two-port arbiter in front of the byte-array data memory (`data_mem`), which only performs full 32-bit writes. Arbitrates between the pipeline MEM stage (core port) and a debug/program-loader port. Applies RV32I size semantics: byte/half loads with sign or zero extension, and byte/half stores via a registered read-modify-write. Also detects misaligned and out-of-range accesses.

## Interface
- `MEM_BYTES`, 1024: memory size in bytes. An access is legal only if `addr + size - 1 < MEM_BYTES`.
- `STARVE_MAX`, 4: number of consecutive ungranted IDLE cycles on the debug port before it takes priority.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `c_req` in 1: core request, held until granted.
- `c_we` in 1: core store (1) or load (0).
- `c_size` in 3: RV32I funct3 of the instruction.
- `c_addr` in 32: core byte address.
- `c_wdata` in 32: core store data; low byte/half used for SB/SH.
- `c_gnt` out 1: core request accepted this cycle (combinational).
- `c_rvalid` out 1: one-cycle completion pulse for loads and stores.
- `c_rdata` out 32: formatted load data; 0 for stores and errors.
- `c_err` out 1: qualifies `c_rvalid`; misaligned, out-of-range or illegal funct3.
- `d_req`, `d_we`, `d_addr[31:0]`, `d_wdata[31:0]`: debug port inputs, word accesses only.
- `d_gnt`, `d_rvalid`, `d_rdata[31:0]`, `d_err`: debug port outputs, same meaning as the core equivalents.
- `mem_addr` out 32: word-aligned address to memory.
- `mem_wdata` out 32: write data to memory.
- `mem_we` out 1: memory write enable.
- `mem_rdata` in 32: combinational read data from memory.

## Operation
- States: IDLE, ACCESS, MERGE.
- **IDLE**
  - `gnt` may assert only in IDLE.
  - The core wins by default. The debug port wins if `c_req` is low, or if the starve counter equals `STARVE_MAX`.
  - On `req & gnt` the transaction (port, we, size, addr, wdata) is latched and the state moves to ACCESS.
- **Starve counter**
  - Increments in each IDLE cycle where `d_req` is high and `d_gnt` is low.
  - Saturates at `STARVE_MAX`.
  - Clears on `d_gnt`.
- **Error check** (evaluated in ACCESS)
  - Conditions: half access with `addr[0]`=1; word access with `addr[1:0]`≠0; illegal funct3; out of range.
  - On error: `mem_we`=0, return to IDLE, and raise `rvalid` with `err`=1 and `rdata`=0 next cycle. Memory is untouched.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - The debug port treats every access as a word access.
- **ACCESS** (legal transaction); `mem_addr = {addr[31:2],2'b00}`
  - Load: select byte/half by `addr[1:0]`, sign- or zero-extend, register into `rdata`, go to IDLE.
  - SW: `mem_we`=1 with `mem_wdata=wdata`, go to IDLE.
  - SB/SH: `mem_we`=0, register `mem_rdata` into the merge register, go to MERGE.
- **MERGE**
  - `mem_we`=1.
  - `mem_wdata` = merge register with the addressed byte/half replaced by `wdata[7:0]` / `wdata[15:0]`.
  - Go to IDLE.
- **Completion**: `rvalid` and `err` are registered and pulse for one cycle on the port that owned the transaction, in the IDLE cycle after the final ACCESS/MERGE cycle.

## Timing
- Load / SW / error: grant in cycle N, ACCESS in N+1, `rvalid` in N+2. A new grant is possible in N+2.
- SB/SH: ACCESS in N+1, MERGE in N+2, `rvalid` in N+3.
- Outside ACCESS/MERGE, `mem_we`=0 and `mem_addr`/`mem_wdata` are 0.
- Both requests arriving in the same cycle: one grant only, per the priority rule. The loser keeps `req` asserted.
- Reset (asynchronous, `rst`=0):
  - State goes to IDLE; the starve counter and all registered outputs go to 0.
  - An in-flight MERGE write is dropped and no `rvalid` is issued.
  - `mem_we` falls immediately.

## Structure
- Shared package `rv_mem_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the state enum (IDLE, ACCESS, MERGE);
  - port-select constants (`PORT_CORE`, `PORT_DBG`).
- Sub-module `mem_lane_fmt` (purely combinational) performs load extract/extend and store byte/half merge from (`size`, `addr[1:0]`, `word`, `wdata`).

## Test plan
- Memory word at 0x10 = 0x80FF_7F01. Core LB @0x11 → `rdata` 0x0000_007F. LB @0x13 → 0xFFFF_FF80. LHU @0x12 → 0x0000_80FF. Each `rvalid` arrives at N+2.
- Core SB 0xAA @0x21 on word 0x1122_3344 → the word becomes 0x1122_AA44. `mem_we` is high only in MERGE, and `rvalid` arrives at N+3.
- Core LH @0x03, SW @0x06, LW @0x400, funct3 011 → each returns `err`=1 with `rdata`=0, and `mem_we` never asserts.
- `c_req` held continuously while `d_req` is held: the debug port is granted after exactly 4 ungranted IDLE cycles, then the counter resets and the core regains priority.
- Simultaneous `c_req` and `d_req` from reset: `c_gnt`=1, `d_gnt`=0. A debug SW then writes 0xDEAD_BEEF @0x0 and a core LW @0x0 reads it back.
- `rst` asserted during MERGE of an SH → `mem_we` drops immediately, the memory word is unchanged, no `rvalid` is issued, and the block is in IDLE after `rst` is released.
